// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI4-Lite register bank terminating the core's AXI4-Lite master bridge.
// Holds NUM_REGS 32-bit read/write registers. Write address and write data
// are captured independently (either order, or together). The write commits
// one cycle after both are held, honouring byte strobes. Every register's
// contents and a one-cycle per-register write pulse are exported.
//
// Ports
//   clk, rst            sole clock; synchronous active-high reset
//   axi_aw*             write address channel (awprot ignored)
//   axi_w*              write data channel with byte strobes
//   axi_b*              write response channel (OKAY / SLVERR)
//   axi_ar*             read address channel (arprot ignored)
//   axi_r*              read data channel (OKAY / SLVERR)
//   reg_out             flattened register contents, reg i at [i*32 +: 32]
//   reg_wr_pulse        bit i high for the cycle reg i first shows a write
// ----------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
    input  logic [2:0]                     axi_awprot,
    input  logic                           axi_awvalid,
    output logic                           axi_awready,
    input  logic [DATA_WIDTH-1:0]          axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
    input  logic                           axi_wvalid,
    output logic                           axi_wready,
    output logic [1:0]                     axi_bresp,
    output logic                           axi_bvalid,
    input  logic                           axi_bready,
    input  logic [ADDR_WIDTH-1:0]          axi_araddr,
    input  logic [2:0]                     axi_arprot,
    input  logic                           axi_arvalid,
    output logic                           axi_arready,
    output logic [DATA_WIDTH-1:0]          axi_rdata,
    output logic [1:0]                     axi_rresp,
    output logic                           axi_rvalid,
    input  logic                           axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int         IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Hit: at or above the base, word aligned, and inside the register window.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (addr[1:0] == 2'b00) &&
               ((offset >> 2) < ADDR_WIDTH'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset[IDX_W+1:2];
    endfunction

    // Write-path state
    logic                  aw_full_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic                  w_full_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg;

    // Read-path state
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic [DATA_WIDTH-1:0] reg_arr [NUM_REGS];

    logic                  aw_hit;
    logic [IDX_W-1:0]      aw_idx;
    logic                  ar_hit;
    logic [IDX_W-1:0]      ar_idx;
    logic                  commit;

    logic                  unused_prot;
    assign unused_prot = ^{axi_awprot, axi_arprot};

    assign aw_hit = addr_hit(aw_addr_reg);
    assign aw_idx = addr_idx(aw_addr_reg);
    assign ar_hit = addr_hit(axi_araddr);
    assign ar_idx = addr_idx(axi_araddr);

    // Captures cannot refill while a response is outstanding, so a commit
    // always sees a single, consistent address/data pair.
    assign commit = aw_full_reg && w_full_reg && !bvalid_reg;

    assign axi_awready  = !rst && !aw_full_reg && !bvalid_reg;
    assign axi_wready   = !rst && !w_full_reg  && !bvalid_reg;
    assign axi_bvalid   = bvalid_reg;
    assign axi_bresp    = bresp_reg;
    assign reg_wr_pulse = wr_pulse_reg;

    assign axi_arready  = !rst && !rvalid_reg;
    assign axi_rvalid   = rvalid_reg;
    assign axi_rdata    = rdata_reg;
    assign axi_rresp    = rresp_reg;

    // ------------------------------------------------------------------
    // Write channel: independent AW/W capture, commit, response hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_reg  <= 1'b0;
            aw_addr_reg  <= '0;
            w_full_reg   <= 1'b0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= '0;
            if (axi_awvalid && axi_awready) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= axi_awaddr;
            end
            if (axi_wvalid && axi_wready) begin
                w_full_reg <= 1'b1;
                w_data_reg <= axi_wdata;
                w_strb_reg <= axi_wstrb;
            end
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                // Pulse fires even with an all-zero strobe: the write happened.
                if (aw_hit) begin
                    wr_pulse_reg[aw_idx] <= 1'b1;
                end
            end else if (bvalid_reg && axi_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register bank: one storage word per register with byte-lane update
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    value_reg <= '0;
                end else if (commit && aw_hit && (aw_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_reg[b]) begin
                            value_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_arr[gi]                            = value_reg;
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel. Sampling reg_arr on the same edge as a commit naturally
    // returns the pre-write value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            if (axi_arvalid && axi_arready) begin
                rvalid_reg <= 1'b1;
                if (ar_hit) begin
                    rdata_reg <= reg_arr[ar_idx];
                    rresp_reg <= RESP_OKAY;
                end else begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end else if (rvalid_reg && axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//
// Self-checking bench for axi_lite_reg_slave. A word-array model of the
// register bank predicts responses, pulses and contents from address decode
// and byte-strobe rules. Inputs are driven and outputs sampled on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int          NREGS = 8;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [31:0]           axi_awaddr;
    logic [2:0]            axi_awprot;
    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [31:0]           axi_wdata;
    logic [3:0]            axi_wstrb;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [31:0]           axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [31:0]           axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [NREGS*32-1:0]   reg_out;
    logic [NREGS-1:0]      reg_wr_pulse;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [NREGS];

    always #5 clk = ~clk;

    axi_lite_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NREGS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axi_awaddr   (axi_awaddr),
        .axi_awprot   (axi_awprot),
        .axi_awvalid  (axi_awvalid),
        .axi_awready  (axi_awready),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_wvalid   (axi_wvalid),
        .axi_wready   (axi_wready),
        .axi_bresp    (axi_bresp),
        .axi_bvalid   (axi_bvalid),
        .axi_bready   (axi_bready),
        .axi_araddr   (axi_araddr),
        .axi_arprot   (axi_arprot),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    // ---------------- reference model ----------------
    function automatic void model_decode(input logic [31:0] addr, output bit hit, output int idx);
        longint off;
        off = longint'(addr) - longint'(BASE);
        hit = (off >= 0) && (off % 4 == 0) && (off / 4 < NREGS);
        idx = hit ? int'(off / 4) : 0;
    endfunction

    function automatic logic [NREGS*32-1:0] model_flat();
        logic [NREGS*32-1:0] f;
        for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = model_regs[i];
        return f;
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold_b);
        bit               hit, aw_done, w_done, aw_fire, w_fire;
        int               idx, cyc, k;
        logic [1:0]       exp_resp;
        logic [NREGS-1:0] exp_pulse;
        model_decode(addr, hit, idx);
        exp_resp  = hit ? 2'b00 : 2'b10;
        exp_pulse = '0;
        if (hit) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi_awaddr  = addr;
            axi_wvalid  = !w_done && (cyc >= w_dly);
            axi_wdata   = data;
            axi_wstrb   = strb;
            #1;
            aw_fire = axi_awvalid && axi_awready;
            w_fire  = axi_wvalid && axi_wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            cyc++;
        end
        checks++;
        if (!(aw_done && w_done)) begin
            errors++;
            $display("FAIL wr_handshake addr=%h: aw_done=%0d w_done=%0d, required both 1", addr, aw_done, w_done);
        end
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        k = 1;
        while (!axi_bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 2) begin
            errors++;
            $display("FAIL wr_latency addr=%h: bvalid seen at sample %0d, required 2", addr, k);
        end
        checks++;
        if (axi_bresp !== exp_resp) begin
            errors++;
            $display("FAIL wr_bresp addr=%h: got %b, required %b", addr, axi_bresp, exp_resp);
        end
        checks++;
        if (reg_wr_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL wr_pulse addr=%h: got %b, required %b", addr, reg_wr_pulse, exp_pulse);
        end
        checks++;
        if (reg_out !== model_flat()) begin
            errors++;
            $display("FAIL wr_regs addr=%h: got %h, required %h", addr, reg_out, model_flat());
        end
        for (int i = 0; i < hold_b; i++) begin
            @(negedge clk);
            checks++;
            if (axi_bvalid !== 1'b1 || axi_bresp !== exp_resp || axi_awready !== 1'b0 ||
                axi_wready !== 1'b0 || reg_wr_pulse !== '0) begin
                errors++;
                $display("FAIL wr_hold cyc=%0d: bvalid=%b bresp=%b awready=%b wready=%b pulse=%b, required 1 %b 0 0 0",
                         i, axi_bvalid, axi_bresp, axi_awready, axi_wready, reg_wr_pulse, exp_resp);
            end
        end
        axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_bready = 1'b0;
        checks++;
        if (axi_bvalid !== 1'b0 || reg_wr_pulse !== '0 || axi_awready !== 1'b1 || axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL wr_release: bvalid=%b pulse=%b awready=%b wready=%b, required 0 0 1 1",
                     axi_bvalid, reg_wr_pulse, axi_awready, axi_wready);
        end
        $display("write addr=%h data=%h strb=%h aw_dly=%0d w_dly=%0d resp=%b", addr, data, strb, aw_dly, w_dly, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold_r,
                           output logic [31:0] rdata, output logic [1:0] rresp);
        bit          hit, done, fire;
        int          idx, cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        model_decode(addr, hit, idx);
        exp_data = hit ? model_regs[idx] : 32'h0;
        exp_resp = hit ? 2'b00 : 2'b10;
        done = 0; cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            axi_arvalid = 1'b1;
            axi_araddr  = addr;
            #1;
            fire = axi_arvalid && axi_arready;
            @(posedge clk);
            if (fire) done = 1;
            cyc++;
        end
        @(negedge clk);
        axi_arvalid = 1'b0;
        checks++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== exp_data || axi_rresp !== exp_resp) begin
            errors++;
            $display("FAIL rd_data addr=%h: rvalid=%b rdata=%h rresp=%b, required 1 %h %b",
                     addr, axi_rvalid, axi_rdata, axi_rresp, exp_data, exp_resp);
        end
        rdata = axi_rdata;
        rresp = axi_rresp;
        for (int i = 0; i < hold_r; i++) begin
            @(negedge clk);
            checks++;
            if (axi_rvalid !== 1'b1 || axi_rdata !== exp_data || axi_rresp !== exp_resp || axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold cyc=%0d: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h %b 0",
                         i, axi_rvalid, axi_rdata, axi_rresp, axi_arready, exp_data, exp_resp);
            end
        end
        axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_rready = 1'b0;
        checks++;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL rd_release: rvalid=%b arready=%b, required 0 1", axi_rvalid, axi_arready);
        end
        $display("read  addr=%h data=%h resp=%b", addr, exp_data, exp_resp);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (axi_awready !== 0 || axi_wready !== 0 || axi_arready !== 0 || axi_bvalid !== 0 ||
            axi_rvalid !== 0 || axi_bresp !== 0 || axi_rresp !== 0 || axi_rdata !== 0 ||
            reg_out !== '0 || reg_wr_pulse !== '0) begin
            errors++;
            $display("FAIL reset_initial: outputs not all zero");
        end
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
        do_write(BASE + 32'h4, 32'h1234_5678, 4'hF, 0, 0, 0);
        // Leave an AW captured and a W pending when reset hits.
        @(negedge clk);
        axi_awvalid = 1'b1;
        axi_awaddr  = BASE + 32'h8;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        axi_wvalid = 1'b1;
        axi_wdata  = 32'hFFFF_FFFF;
        axi_wstrb  = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (axi_awready !== 0 || axi_wready !== 0 || axi_arready !== 0 || axi_bvalid !== 0 ||
                axi_rvalid !== 0 || axi_rdata !== 0 || reg_out !== '0 || reg_wr_pulse !== '0) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d: awready=%b wready=%b arready=%b bvalid=%b reg_out=%h, required all 0",
                         i, axi_awready, axi_wready, axi_arready, axi_bvalid, reg_out);
            end
        end
        rst = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 32'h0;
        @(negedge clk);
        checks++;
        if (axi_awready !== 1 || axi_wready !== 1 || axi_arready !== 1 || axi_bvalid !== 0) begin
            errors++;
            $display("FAIL reset_release: awready=%b wready=%b arready=%b bvalid=%b, required 1 1 1 0",
                     axi_awready, axi_wready, axi_arready, axi_bvalid);
        end
        $display("reset mid-transaction released");
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
        checks++;
        if (reg_out[63:32] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_reg1: got %h, required deadbeef", reg_out[63:32]);
        end
        do_read(BASE + 32'h4, 0, d, r);
        checks++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            errors++;
            $display("FAIL readback_reg1: got %h/%b, required deadbeef/00", d, r);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(BASE + 32'h8, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(BASE + 32'h8, 32'hAABB_CCDD, 4'h5, 2, 0, 0);
        checks++;
        if (reg_out[95:64] !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_merge: got %h, required 11bb33dd", reg_out[95:64]);
        end
        do_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);
        do_read(BASE + 32'h8, 0, d, r);
        checks++;
        if (d !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_zero: got %h, required 11bb33dd", d);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(BASE + 32'h20, 32'hCAFE_0001, 4'hF, 0, 0, 0);
        do_write(BASE + 32'h2,  32'hCAFE_0002, 4'hF, 0, 0, 0);
        do_write(BASE - 32'h4,  32'hCAFE_0003, 4'hF, 1, 0, 0);
        do_read(BASE + 32'h4, 0, d, r);
        do_read(BASE + 32'h20, 0, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++;
            $display("FAIL read_oob: got %h/%b, required 00000000/10", d, r);
        end
        do_read(BASE + 32'h3, 0, d, r);
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(BASE + 32'hC, 32'h5A5A_A5A5, 4'hF, 0, 0, 5);
        do_read(BASE + 32'hC, 4, d, r);
    endtask

    task automatic test_collision();
        logic [31:0] d, pre;
        logic [1:0]  r;
        do_write(BASE, 32'h1, 4'hF, 0, 0, 0);
        pre = model_regs[0];
        @(negedge clk);
        axi_awvalid = 1'b1; axi_awaddr = BASE;
        axi_wvalid  = 1'b1; axi_wdata = 32'h2; axi_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        axi_arvalid = 1'b1; axi_araddr = BASE;
        @(posedge clk);
        @(negedge clk);
        axi_arvalid = 1'b0;
        model_regs[0] = 32'h2;
        checks++;
        if (axi_rvalid !== 1 || axi_rdata !== pre || axi_bvalid !== 1 || reg_out[31:0] !== 32'h2) begin
            errors++;
            $display("FAIL collision: rvalid=%b rdata=%h bvalid=%b reg0=%h, required 1 %h 1 00000002",
                     axi_rvalid, axi_rdata, axi_bvalid, reg_out[31:0], pre);
        end
        axi_bready = 1'b1; axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_bready = 1'b0; axi_rready = 1'b0;
        checks++;
        if (axi_bvalid !== 0 || axi_rvalid !== 0) begin
            errors++;
            $display("FAIL collision_release: bvalid=%b rvalid=%b, required 0 0", axi_bvalid, axi_rvalid);
        end
        $display("collision write/read reg0 pre=%h", pre);
        do_read(BASE, 0, d, r);
    endtask

    task automatic test_random();
        logic [31:0] addr, d;
        logic [1:0]  r;
        for (int n = 0; n < 40; n++) begin
            addr = BASE + 32'($urandom_range(0, 9)) * 4;
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) addr = BASE - 32'h4;
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                do_read(addr, $urandom_range(0, 2), d, r);
        end
    endtask

    initial begin
        rst = 1'b1;
        axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wdata  = '0; axi_wstrb  = '0; axi_wvalid  = 1'b0;
        axi_bready = 1'b0;
        axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b0;
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_backpressure();
        test_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
